// File: rtl/serial_sub_pkg.sv
// Types shared by the bit-serial subtractor; encodings come from the common defs file.
`include "serial_defs.vh"

package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = `SERIAL_ST_IDLE,
    RUN  = `SERIAL_ST_RUN,
    DONE = `SERIAL_ST_DONE
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit combinational subtract step: diff = x - y - bin, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_defs.vh
// Shared state encodings for the bit-serial arithmetic blocks.
`ifndef SERIAL_DEFS_VH
`define SERIAL_DEFS_VH
`define SERIAL_ST_IDLE 2'd0
`define SERIAL_ST_RUN  2'd1
`define SERIAL_ST_DONE 2'd2
`endif

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: LSB-first, one bit per clock, WIDTH+2 cycles per result.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             step_diff;
  logic             step_bout;
  logic             last_step;

  full_subtractor u_fs (
    .x    (sa[0]),
    .y    (sb[0]),
    .bin  (borrow),
    .diff (step_diff),
    .bout (step_bout)
  );

  assign last_step = (cnt == LAST);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) state_nx = RUN;
        else       state_nx = IDLE;
      end
      RUN: begin
        if (last_step) state_nx = DONE;
        else           state_nx = RUN;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
      done  <= (state_nx == DONE);
    end
  end

  // Operand shifters, result shifter and borrow chain; d/bout load only on the last step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      d      <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa     <= a;
            sb     <= b;
            res    <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
          end
        end
        RUN: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          res    <= {step_diff, res[WIDTH-1:1]};
          borrow <= step_bout;
          cnt    <= cnt + CW'(1);
          if (last_step) begin
            d    <= {step_diff, res[WIDTH-1:1]};
            bout <= step_bout;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub at WIDTH=3 and WIDTH=8 against an arithmetic reference.
module tb_serial_sub;

  logic       clk;
  logic       reset;
  logic       start3, start8;
  logic [2:0] a3, b3, d3;
  logic [7:0] a8, b8, d8;
  logic       busy3, done3, bout3;
  logic       busy8, done8, bout8;

  int total;
  int bad;

  serial_sub #(.WIDTH(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .d(d3), .bout(bout3)
  );

  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .d(d8), .bout(bout8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [2:0] ref_d3(input int x, input int y);
    ref_d3 = 3'((x - y + 8) % 8);
  endfunction

  function automatic logic [7:0] ref_d8(input int x, input int y);
    ref_d8 = 8'((x - y + 256) % 256);
  endfunction

  // Launch one WIDTH=3 operation, wait (bounded) for done, then one more cycle so the DUT is idle.
  task automatic do_op3(input logic [2:0] xa, input logic [2:0] xb,
                        output logic [2:0] rd, output logic rb, output int lat);
    @(negedge clk);
    start3 = 1'b1; a3 = xa; b3 = xb;
    lat = 0;
    rd = 3'd0; rb = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start3 = 1'b0;
      a3 = 3'($urandom); b3 = 3'($urandom);
      if (done3 === 1'b1) begin
        lat = n; rd = d3; rb = bout3;
        break;
      end
    end
    if (lat == 0) lat = 99;
    @(negedge clk);
  endtask

  task automatic do_op8(input logic [7:0] xa, input logic [7:0] xb,
                        output logic [7:0] rd, output logic rb, output int lat);
    @(negedge clk);
    start8 = 1'b1; a8 = xa; b8 = xb;
    lat = 0;
    rd = 8'd0; rb = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom);
      if (done8 === 1'b1) begin
        lat = n; rd = d8; rb = bout8;
        break;
      end
    end
    if (lat == 0) lat = 99;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({busy3, done3, d3, bout3} !== 6'd0) begin
      bad++; $display("FAIL reset3: got busy=%b done=%b d=%0d bout=%b, want all 0", busy3, done3, d3, bout3);
    end
    total++;
    if ({busy8, done8, d8, bout8} !== 11'd0) begin
      bad++; $display("FAIL reset8: got busy=%b done=%b d=%0d bout=%b, want all 0", busy8, done8, d8, bout8);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk);
    start3 = 1'b1; a3 = 3'd3; b3 = 3'd1;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      start3 = 1'b0;
      total++;
      if (busy3 !== (n >= 1 && n <= 4)) begin
        bad++; $display("FAIL basic_busy cycle %0d: got %b want %b", n, busy3, (n >= 1 && n <= 4));
      end
      total++;
      if (done3 !== (n == 4)) begin
        bad++; $display("FAIL basic_done cycle %0d: got %b want %b", n, done3, (n == 4));
      end
      if (n == 4) begin
        total++;
        if (d3 !== 3'd2 || bout3 !== 1'b0) begin
          bad++; $display("FAIL basic_result: got d=%0d bout=%b want d=2 bout=0", d3, bout3);
        end
      end
    end
  endtask

  task automatic test_vectors();
    logic [2:0] va[4];
    logic [2:0] vb[4];
    logic [2:0] rd;
    logic       rb;
    int         lat;
    va = '{3'd0, 3'd4, 3'd7, 3'd5};
    vb = '{3'd1, 3'd5, 3'd0, 3'd5};
    for (int i = 0; i < 4; i++) begin
      do_op3(va[i], vb[i], rd, rb, lat);
      total++;
      if (rd !== ref_d3(int'(va[i]), int'(vb[i])) || rb !== (va[i] < vb[i]) || lat != 4) begin
        bad++;
        $display("FAIL vector %0d-%0d: got d=%0d bout=%b lat=%0d want d=%0d bout=%b lat=4",
                 va[i], vb[i], rd, rb, lat, ref_d3(int'(va[i]), int'(vb[i])), (va[i] < vb[i]));
      end
    end
  endtask

  task automatic test_ignore_start();
    int ndone;
    ndone = 0;
    @(negedge clk);
    start3 = 1'b1; a3 = 3'd3; b3 = 3'd2;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      start3 = (n == 2);
      a3 = (n == 2) ? 3'd7 : 3'd0;
      b3 = (n == 2) ? 3'd1 : 3'd0;
      if (done3 === 1'b1) begin
        ndone++;
        total++;
        if (d3 !== 3'd1 || bout3 !== 1'b0 || n != 4) begin
          bad++; $display("FAIL ignore_result: got d=%0d bout=%b at cycle %0d want d=1 bout=0 at 4", d3, bout3, n);
        end
      end
    end
    start3 = 1'b0;
    total++;
    if (ndone != 1) begin
      bad++; $display("FAIL ignore_count: got %0d done pulses want 1", ndone);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] rd;
    logic       rb;
    int         lat;
    int         ndone;
    do_op3(3'd0, 3'd1, rd, rb, lat);
    @(negedge clk);
    start3 = 1'b1; a3 = 3'd2; b3 = 3'd1;
    @(negedge clk);
    start3 = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    total++;
    if ({busy3, done3, d3, bout3} !== 6'd0) begin
      bad++; $display("FAIL midreset_clear: got busy=%b done=%b d=%0d bout=%b want all 0", busy3, done3, d3, bout3);
    end
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done3 === 1'b1 || busy3 !== 1'b0) ndone++;
    end
    total++;
    if (ndone != 0) begin
      bad++; $display("FAIL midreset_quiet: got %0d cycles with done/busy set want 0", ndone);
    end
    do_op3(3'd4, 3'd3, rd, rb, lat);
    total++;
    if (rd !== 3'd1 || rb !== 1'b0 || lat != 4) begin
      bad++; $display("FAIL midreset_next: got d=%0d bout=%b lat=%0d want d=1 bout=0 lat=4", rd, rb, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] oa[3];
    logic [2:0] ob[3];
    int         idx, last_n;
    logic [2:0] held_d;
    logic       held_b;
    for (int i = 0; i < 3; i++) begin
      oa[i] = 3'($urandom); ob[i] = 3'($urandom);
    end
    idx = 0; last_n = 0; held_d = 3'd0; held_b = 1'b0;
    @(negedge clk);
    start3 = 1'b1; a3 = oa[0]; b3 = ob[0];
    for (int n = 1; n <= 22; n++) begin
      @(negedge clk);
      if (done3 === 1'b1) begin
        if (idx < 3) begin
          total++;
          if (d3 !== ref_d3(int'(oa[idx]), int'(ob[idx])) || bout3 !== (oa[idx] < ob[idx])) begin
            bad++; $display("FAIL b2b_result %0d: got d=%0d bout=%b want d=%0d bout=%b",
                            idx, d3, bout3, ref_d3(int'(oa[idx]), int'(ob[idx])), (oa[idx] < ob[idx]));
          end
          if (idx > 0) begin
            total++;
            if (n - last_n != 5) begin
              bad++; $display("FAIL b2b_spacing %0d: got %0d cycles want 5", idx, n - last_n);
            end
          end
        end
        last_n = n; held_d = d3; held_b = bout3;
        idx++;
        if (idx < 3) begin
          a3 = oa[idx]; b3 = ob[idx];
        end else begin
          start3 = 1'b0;
        end
      end else if (idx > 0) begin
        total++;
        if (d3 !== held_d || bout3 !== held_b) begin
          bad++; $display("FAIL b2b_stable cycle %0d: got d=%0d bout=%b want d=%0d bout=%b", n, d3, bout3, held_d, held_b);
        end
      end
    end
    start3 = 1'b0;
    total++;
    if (idx != 3) begin
      bad++; $display("FAIL b2b_count: got %0d done pulses want 3", idx);
    end
  endtask

  task automatic test_sweep();
    logic [2:0] rd;
    logic       rb;
    int         lat;
    for (int x = 0; x < 8; x++) begin
      for (int y = 0; y < 8; y++) begin
        do_op3(3'(x), 3'(y), rd, rb, lat);
        total++;
        if (rd !== ref_d3(x, y) || rb !== (x < y) || lat != 4) begin
          bad++; $display("FAIL sweep %0d-%0d: got d=%0d bout=%b lat=%0d want d=%0d bout=%b lat=4",
                          x, y, rd, rb, lat, ref_d3(x, y), (x < y));
        end
      end
    end
  endtask

  task automatic test_wide();
    logic [7:0] rd;
    logic       rb;
    int         lat;
    int         x, y;
    do_op8(8'h10, 8'h01, rd, rb, lat);
    total++;
    if (rd !== 8'h0F || rb !== 1'b0 || lat != 9) begin
      bad++; $display("FAIL wide_spot: got d=%h bout=%b lat=%0d want d=0f bout=0 lat=9", rd, rb, lat);
    end
    for (int i = 0; i < 6; i++) begin
      x = int'($urandom_range(255, 0));
      y = int'($urandom_range(255, 0));
      do_op8(8'(x), 8'(y), rd, rb, lat);
      total++;
      if (rd !== ref_d8(x, y) || rb !== (x < y) || lat != 9) begin
        bad++; $display("FAIL wide_rand %0d-%0d: got d=%0d bout=%b lat=%0d want d=%0d bout=%b lat=9",
                        x, y, rd, rb, lat, ref_d8(x, y), (x < y));
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1;
    start3 = 1'b0; a3 = 3'd0; b3 = 3'd0;
    start8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    test_reset();
    test_basic();
    test_vectors();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
